// File: rtl/bcd_conv_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bcd_conv_sched                                                   |
// | Brief   : Round-robin scheduler sharing one binary-to-BCD converter among  |
// |           N_REQ display-field requesters; results are tagged with the id.  |
// |           Optional macro VSYNC_COMMIT_EN holds each result until vs rises. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module bcd_conv_sched #(
    parameter int N_REQ   = 4,
    parameter int BIN_W   = 12,
    parameter int BCD_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*BIN_W-1:0]   req_data,
    output logic [N_REQ-1:0]         req_pending,
    output logic                     conv_bin_valid,
    output logic [BIN_W-1:0]         conv_bin,
    input  logic                     conv_ready,
    input  logic [BCD_W-1:0]         conv_bcd,
    input  logic                     conv_bcd_valid,
    output logic                     res_valid,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic [BCD_W-1:0]         res_bcd,
    input  logic                     vs,
    output logic                     timeout_err
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]       r_state;
    logic [N_REQ-1:0] r_pend;
    logic [BIN_W-1:0] r_hold [N_REQ];
    logic [ID_W-1:0]  r_rr;
    logic [ID_W-1:0]  r_id;
    logic [BIN_W-1:0] r_val;
    logic [CNT_W-1:0] r_cnt;
    logic             r_res_valid;
    logic [ID_W-1:0]  r_res_id;
    logic [BCD_W-1:0] r_res_bcd;
    logic             r_timeout;

    logic             w_gnt_found;
    logic [ID_W-1:0]  w_gnt_id;
    logic [ID_W:0]    w_sum;
    logic             w_grant;
    logic [ID_W-1:0]  w_rr_next;

`ifdef VSYNC_COMMIT_EN
    logic             r_vs;
    logic             r_vs_hit;
    logic [BCD_W-1:0] r_bcd;
    logic             w_vs_rise;
    assign w_vs_rise = vs & ~r_vs;
`else
    logic             w_unused_vs;
    assign w_unused_vs = vs;
`endif

    // Scan from the highest offset down so the nearest pending index at/after rr wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        w_sum       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr} + (ID_W + 1)'(k);
            if (w_sum >= (ID_W + 1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W + 1)'(N_REQ);
            end
            if (r_pend[w_sum[ID_W-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_grant   = (r_state == S_IDLE) && conv_ready && w_gnt_found;
    assign w_rr_next = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pend      <= '0;
            r_rr        <= '0;
            r_id        <= '0;
            r_val       <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_bcd   <= '0;
            r_timeout   <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                r_hold[i] <= '0;
            end
`ifdef VSYNC_COMMIT_EN
            r_vs        <= 1'b0;
            r_vs_hit    <= 1'b0;
            r_bcd       <= '0;
`endif
        end else begin
`ifdef VSYNC_COMMIT_EN
            r_vs <= vs;
`endif
            // A post in the grant cycle re-arms the pend bit after the grant clears it.
            if (w_grant) begin
                r_pend[w_gnt_id] <= 1'b0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i]) begin
                    r_pend[i] <= 1'b1;
                    r_hold[i] <= req_data[i*BIN_W +: BIN_W];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_val   <= r_hold[w_gnt_id];
                        r_id    <= w_gnt_id;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= CNT_W'(TIMEOUT);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (conv_bcd_valid) begin
`ifdef VSYNC_COMMIT_EN
                        r_bcd       <= conv_bcd;
                        r_vs_hit    <= w_vs_rise;
`else
                        r_res_valid <= 1'b1;
                        r_res_bcd   <= conv_bcd;
                        r_res_id    <= r_id;
`endif
                        r_state     <= S_COMMIT;
                    end else if (r_cnt == '0) begin
                        r_timeout <= 1'b1;
                        r_rr      <= w_rr_next;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_COMMIT: begin
`ifdef VSYNC_COMMIT_EN
                    if (r_res_valid) begin
                        r_res_valid <= 1'b0;
                        r_vs_hit    <= 1'b0;
                        r_rr        <= w_rr_next;
                        r_state     <= S_IDLE;
                    end else if (w_vs_rise || r_vs_hit) begin
                        r_res_valid <= 1'b1;
                        r_res_bcd   <= r_bcd;
                        r_res_id    <= r_id;
                    end
`else
                    r_res_valid <= 1'b0;
                    r_rr        <= w_rr_next;
                    r_state     <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_pending    = r_pend;
    assign conv_bin_valid = (r_state == S_ISSUE);
    assign conv_bin       = r_val;
    assign res_valid      = r_res_valid;
    assign res_id         = r_res_id;
    assign res_bcd        = r_res_bcd;
    assign timeout_err    = r_timeout;

endmodule
`default_nettype wire
